// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response encodings and write-channel FSM states shared by the memory controller.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_W, W_RESP} wstate_e;
endpackage

// File: rtl/axil_mem_ctrl_ram.sv
// axil_mem_ctrl_ram: single-clock RAM with a byte-enabled write port and a registered read port.
module axil_mem_ctrl_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IW         = 10
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic [IW-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [IW-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (we_i)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (wbe_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/axil_mem_ctrl.sv
// axil_mem_ctrl: AXI4-Lite slave in front of a word-addressed RAM with independent AW/W capture
// and a single-entry read pipeline.
module axil_mem_ctrl
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp
);
    localparam int SW  = DATA_WIDTH/8;
    localparam int OFF = $clog2(SW);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

    wstate_e               state_q, state_d;
    logic [IW-1:0]         aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic                  rdy_q, rvalid_q, rok_q;
    logic                  aw_hs, w_hs, ar_hs, have_a, have_w, w_fire, w_in, r_in;
    logic [IW-1:0]         w_idx, r_idx;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
    logic [SW-1:0]         ram_wbe;
    logic                  unused_ok;

    // rdy_q keeps both write channels closed during reset and until the first cycle after release.
    assign awready   = rdy_q && (state_q == W_IDLE || state_q == W_HAVE_W);
    assign wready    = rdy_q && (state_q == W_IDLE || state_q == W_HAVE_A);
    assign bvalid    = state_q == W_RESP;
    assign bresp     = bresp_q;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign have_a    = aw_hs || state_q == W_HAVE_A;
    assign have_w    = w_hs || state_q == W_HAVE_W;
    assign w_idx     = aw_hs ? awaddr[ADDR_WIDTH-1:OFF] : aw_idx_q;
    assign w_in      = {1'b0, w_idx} < DEPTH_W;
    assign ram_wdata = w_hs ? wdata : wdata_q;
    assign ram_wbe   = w_hs ? wstrb : wstrb_q;
    assign w_fire    = reset && state_q != W_RESP && state_d == W_RESP;
    assign unused_ok = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};

    always_comb begin
        state_d = state_q;
        state_d = (state_q == W_RESP) ? (bready ? W_IDLE : W_RESP) :
                  (have_a && have_w)  ? W_RESP :
                  have_a              ? W_HAVE_A :
                  have_w              ? W_HAVE_W : W_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= W_IDLE;
            bresp_q <= RESP_OKAY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (w_fire) bresp_q <= w_in ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) aw_idx_q <= awaddr[ADDR_WIDTH-1:OFF];
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    assign arready = !rvalid_q || rready;
    assign ar_hs   = arvalid && arready;
    assign r_idx   = araddr[ADDR_WIDTH-1:OFF];
    assign r_in    = {1'b0, r_idx} < DEPTH_W;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rok_q ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rok_q    <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= r_in ? RESP_OKAY : RESP_SLVERR;
            rok_q    <= r_in;
        end else if (rready) begin
            rvalid_q <= 1'b0;
        end
    end

    axil_mem_ctrl_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk     (clk),
        .we_i    (w_fire && w_in),
        .wbe_i   (ram_wbe),
        .waddr_i (w_idx),
        .wdata_i (ram_wdata),
        .re_i    (ar_hs && r_in && reset),
        .raddr_i (r_idx),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_axil_mem_ctrl.sv
// tb_axil_mem_ctrl: scoreboard bench for axil_mem_ctrl (32-bit data, DEPTH=1000) with a byte-lane memory model.
module tb_axil_mem_ctrl;
    localparam int DEPTH = 1000;

    logic        clk = 1'b0, reset = 1'b0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [11:0] awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;
    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mdl [int];
    int          n_tests = 0, n_fail = 0;
    logic [11:0] b2b_addr [3] = '{12'h010, 12'h040, 12'h050};

    axil_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) >> 2;
        if (idx >= DEPTH) begin
            bq.push_back(2'b10);
            return;
        end
        bq.push_back(2'b00);
        if (!mdl.exists(idx)) mdl[idx] = 32'h0;
        for (int i = 0; i < 4; i++)
            if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic push_read(input logic [11:0] a);
        int idx;
        idx = int'(a) >> 2;
        if (idx >= DEPTH) rq.push_back('{32'h0, 2'b10});
        else rq.push_back('{mdl[idx], 2'b00});
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lead);
        awaddr = a; wdata = d; wstrb = s;
        if (w_lead > 0) begin
            wvalid = 1;
            tick();
            wvalid = 0;
            check("have_w_wready", wready, 0);
            check("have_w_awready", awready, 1);
            repeat (w_lead - 1) tick();
            awvalid = 1;
            tick();
            awvalid = 0;
        end else begin
            awvalid = 1; wvalid = 1;
            tick();
            awvalid = 0; wvalid = 0;
        end
        model_write(a, d, s);
    endtask

    task automatic get_b();
        bready = 1;
        for (int i = 0; i < 20; i++) begin
            if (bvalid) begin
                check("bresp", bresp, bq.pop_front());
                tick();
                bready = 0;
                return;
            end
            tick();
        end
        check("b_timeout", bvalid, 1);
        bready = 0;
    endtask

    task automatic do_read(input logic [11:0] a);
        push_read(a);
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && !arready; i++) tick();
        tick();
        arvalid = 0;
    endtask

    task automatic get_r();
        rexp_t e;
        rready = 1;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) begin
                e = rq.pop_front();
                check("rdata", rdata, e.d);
                check("rresp", rresp, e.r);
                tick();
                rready = 0;
                return;
            end
            tick();
        end
        check("r_timeout", rvalid, 1);
        rready = 0;
    endtask

    task automatic read(input logic [11:0] a);
        do_read(a);
        get_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rexp_t e;
        tick(); tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        reset = 1;
        tick();
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);

        // Full write with AW and W together, then read back.
        do_write(12'h010, 32'hDEADBEEF, 4'hF, 0);
        check("bvalid_next", bvalid, 1);
        check("resp_awready", awready, 0);
        check("resp_wready", wready, 0);
        get_b();
        read(12'h010);

        // All strobes low writes nothing.
        do_write(12'h010, 32'hFFFFFFFF, 4'h0, 0);
        get_b();
        read(12'h010);

        // W leads AW by three cycles, single lane.
        do_write(12'h040, 32'h11223344, 4'hF, 0);
        get_b();
        do_write(12'h040, 32'h000000AA, 4'h1, 3);
        get_b();
        read(12'h040);

        // Out of range.
        do_write(12'hFA0, 32'h12345678, 4'hF, 0);
        get_b();
        read(12'hFA0);
        read(12'h010);

        // Read back-pressure.
        do_read(12'h010);
        e = rq[0];
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", rvalid, 1);
            check("bp_rdata", rdata, e.d);
            check("bp_rresp", rresp, e.r);
            check("bp_arready", arready, 0);
            tick();
        end
        get_r();

        // Write back-pressure.
        do_write(12'h050, 32'hCAFEF00D, 4'hF, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid", bvalid, 1);
            check("bp_bresp", bresp, 0);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
            tick();
        end
        get_b();

        // Back-to-back reads, one per cycle.
        rready = 1; arvalid = 1;
        for (int i = 0; i < 3; i++) begin
            araddr = b2b_addr[i];
            push_read(b2b_addr[i]);
            check("b2b_arready", arready, 1);
            tick();
            e = rq.pop_front();
            check("b2b_rvalid", rvalid, 1);
            check("b2b_rdata", rdata, e.d);
        end
        arvalid = 0;
        tick();
        check("b2b_rvalid_clr", rvalid, 0);
        rready = 0;

        // Same-edge read and write: read-first.
        do_write(12'h020, 32'h1, 4'hF, 0);
        get_b();
        awaddr = 12'h020; wdata = 32'h2; wstrb = 4'hF; araddr = 12'h020;
        push_read(12'h020);
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        model_write(12'h020, 32'h2, 4'hF);
        get_b();
        get_r();
        read(12'h020);

        // Reset while in W_HAVE_A, with W offered on the reset edge.
        do_write(12'h030, 32'h55, 4'hF, 0);
        get_b();
        awaddr = 12'h030; awvalid = 1;
        tick();
        awvalid = 0;
        check("have_a_awready", awready, 0);
        check("have_a_wready", wready, 1);
        reset = 0; wvalid = 1; wdata = 32'hBAD; wstrb = 4'hF;
        tick();
        wvalid = 0;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_wready", wready, 0);
        tick();
        reset = 1;
        tick();
        check("rel_bvalid", bvalid, 0);
        check("rel_awready", awready, 1);
        read(12'h030);
        do_write(12'h030, 32'h66, 4'hF, 0);
        get_b();
        read(12'h030);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_mem_ctrl.md
AXIL_MEM_CTRL -- requirements
Module: axil_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width in bits (32 or 64 only).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, memory depth in words; SHALL be at most 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)) and need not be a power of two.
REQ-004 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have awvalid/awready  in/out  1/1  write-address handshake.
REQ-007 SHALL have awaddr  input  ADDR_WIDTH  write byte address.
REQ-008 SHALL have wvalid/wready  in/out  1/1  write-data handshake.
REQ-009 SHALL have wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have wstrb  input  DATA_WIDTH/8  byte-lane enables.
REQ-011 SHALL have bvalid/bready  out/in  1/1  write-response handshake.
REQ-012 SHALL have bresp  output  2  write response: OKAY=00, SLVERR=10.
REQ-013 SHALL have arvalid/arready  in/out  1/1  read-address handshake.
REQ-014 SHALL have araddr  input  ADDR_WIDTH  read byte address.
REQ-015 SHALL have rvalid/rready  out/in  1/1  read-data handshake.
REQ-016 SHALL have rdata  output  DATA_WIDTH  read data.
REQ-017 SHALL have rresp  output  2  read response: OKAY=00, SLVERR=10.

Function
REQ-018 SHALL form word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored; index >= DEPTH is out of range.
REQ-019 SHALL run the write FSM with states W_IDLE (awready=1, wready=1), W_HAVE_A (awready=0, wready=1), W_HAVE_W (awready=1, wready=0) and W_RESP (awready=0, wready=0, bvalid=1).
REQ-020 SHALL capture AW and W independently: W_IDLE goes to W_HAVE_A on AW only, to W_HAVE_W on W only, and to W_RESP on both in the same cycle; W_HAVE_A/W_HAVE_W go to W_RESP on the missing handshake.
REQ-021 SHALL perform the memory write on the edge entering W_RESP, updating only lanes with wstrb=1; wstrb=0 on all lanes gives a write of nothing and an OKAY response.
REQ-022 SHALL skip the write for an out-of-range index and return bresp=SLVERR.
REQ-023 SHALL hold bvalid and bresp stable in W_RESP until bready=1, then return to W_IDLE on the next edge (no write accepted during W_RESP).
REQ-024 SHALL drive arready = !rvalid || rready (combinational) so back-to-back reads sustain one per cycle.
REQ-025 SHALL, on an AR handshake, register rdata = mem[index] and rvalid=1 on the next edge (latency 1); out-of-range gives rdata=0 and rresp=SLVERR.
REQ-026 SHALL hold rvalid, rdata and rresp stable while rvalid=1 and rready=0; rvalid clears after rready=1 if no new AR handshake occurs.
REQ-027 SHALL make reads and writes fully concurrent; a read and a write to the same word on the same edge return the pre-write contents (read-first).
REQ-028 SHALL leave memory contents uninitialised; they are not reset.

Reset
REQ-029 SHALL, while reset=0, force the write FSM to W_IDLE with awready=0, wready=0, bvalid=0, bresp=00, rvalid=0, rdata=0 and rresp=00; awready and wready rise on the first cycle after release.
REQ-030 SHALL abandon any partially captured write on a reset assertion mid-transaction, without writing memory and without issuing a response.

Structure
REQ-031 SHALL place the response encodings (RESP_OKAY, RESP_SLVERR) and the write-FSM state typedef in the shared package axil_pkg.
REQ-032 SHALL implement storage in a sub-module axil_mem_ctrl_ram, a single-clock RAM with one write port and one read port, per-byte write enable and a registered read.

Verification
REQ-033 SHALL cover a full write: AW 0x010 and W 0xDEADBEEF with wstrb=F in the same cycle -> bvalid the next cycle with bresp=00; AR 0x010 -> rdata=0xDEADBEEF.
REQ-034 SHALL cover a partial write: W precedes AW by 3 cycles, data 0x000000AA, wstrb=1, over a word holding 0x11223344 -> the word reads back 0x112233AA.
REQ-035 SHALL cover out-of-range access: DEPTH=1000 at 32 bits, write to 0xFA0 -> bresp=10 and memory unchanged; read from 0xFA0 -> rresp=10, rdata=0.
REQ-036 SHALL cover back-pressure: rready held 0 for 5 cycles -> rdata/rresp stable and arready=0; bready held 0 -> bvalid held and awready=wready=0.
REQ-037 SHALL cover a same-edge read/write to 0x020 (old 0x1, new 0x2) -> read returns 0x1, and a following read returns 0x2.
REQ-038 SHALL cover reset in W_HAVE_A -> no memory change, bvalid=0, and a fresh write completes normally after reset release.
